// File: rtl/ps2_char_glyph_unit_pkg.sv
// Shared constants, scan-code map and glyph ROM for the PS/2 glyph unit.
// The ROM holds 8x8 shapes centred vertically in an 8x16 cell.
package ps2_char_glyph_unit_pkg;

  localparam int TIMEOUT_DFLT = 65536;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_0     = 7'h30;
  localparam logic [6:0] ASCII_A     = 7'h41;

  typedef struct packed {
    logic       hit;
    logic [6:0] code;
  } key_t;

  function automatic key_t scan_map(input logic [7:0] sc);
    key_t k;
    k.hit  = 1'b1;
    k.code = ASCII_SPACE;
    case (sc)
      8'h1C: k.code = 7'h41;
      8'h32: k.code = 7'h42;
      8'h21: k.code = 7'h43;
      8'h23: k.code = 7'h44;
      8'h24: k.code = 7'h45;
      8'h2B: k.code = 7'h46;
      8'h34: k.code = 7'h47;
      8'h33: k.code = 7'h48;
      8'h43: k.code = 7'h49;
      8'h3B: k.code = 7'h4A;
      8'h42: k.code = 7'h4B;
      8'h4B: k.code = 7'h4C;
      8'h3A: k.code = 7'h4D;
      8'h31: k.code = 7'h4E;
      8'h44: k.code = 7'h4F;
      8'h4D: k.code = 7'h50;
      8'h15: k.code = 7'h51;
      8'h2D: k.code = 7'h52;
      8'h1B: k.code = 7'h53;
      8'h2C: k.code = 7'h54;
      8'h3C: k.code = 7'h55;
      8'h2A: k.code = 7'h56;
      8'h1D: k.code = 7'h57;
      8'h22: k.code = 7'h58;
      8'h35: k.code = 7'h59;
      8'h1A: k.code = 7'h5A;
      8'h45: k.code = 7'h30;
      8'h16: k.code = 7'h31;
      8'h1E: k.code = 7'h32;
      8'h26: k.code = 7'h33;
      8'h25: k.code = 7'h34;
      8'h2E: k.code = 7'h35;
      8'h36: k.code = 7'h36;
      8'h3D: k.code = 7'h37;
      8'h3E: k.code = 7'h38;
      8'h46: k.code = 7'h39;
      SC_SPACE: k.code = ASCII_SPACE;
      default: k.hit = 1'b0;
    endcase
    return k;
  endfunction

  function automatic logic [127:0] glyph_rom(input logic [6:0] c);
    logic [63:0] r;
    case (c)
      7'h41: r = 64'h183C66667E666600;
      7'h42: r = 64'h7C66667C66667C00;
      7'h43: r = 64'h3C66606060663C00;
      7'h44: r = 64'h786C6666666C7800;
      7'h45: r = 64'h7E60607860607E00;
      7'h46: r = 64'h7E60607860606000;
      7'h47: r = 64'h3C66606E66663C00;
      7'h48: r = 64'h6666667E66666600;
      7'h49: r = 64'h3C18181818183C00;
      7'h4A: r = 64'h1E0C0C0C0C6C3800;
      7'h4B: r = 64'h666C7870786C6600;
      7'h4C: r = 64'h6060606060607E00;
      7'h4D: r = 64'h63777F6B63636300;
      7'h4E: r = 64'h66767E7E6E666600;
      7'h4F: r = 64'h3C66666666663C00;
      7'h50: r = 64'h7C66667C60606000;
      7'h51: r = 64'h3C666666663C0E00;
      7'h52: r = 64'h7C66667C786C6600;
      7'h53: r = 64'h3C66603C06663C00;
      7'h54: r = 64'h7E18181818181800;
      7'h55: r = 64'h6666666666663C00;
      7'h56: r = 64'h66666666663C1800;
      7'h57: r = 64'h6363636B7F776300;
      7'h58: r = 64'h66663C183C666600;
      7'h59: r = 64'h6666663C18181800;
      7'h5A: r = 64'h7E060C1830607E00;
      7'h30: r = 64'h3C666E7666663C00;
      7'h31: r = 64'h1818381818187E00;
      7'h32: r = 64'h3C66060C30607E00;
      7'h33: r = 64'h3C66061C06663C00;
      7'h34: r = 64'h060E1E667F060600;
      7'h35: r = 64'h7E607C0606663C00;
      7'h36: r = 64'h3C66607C66663C00;
      7'h37: r = 64'h7E660C1818181800;
      7'h38: r = 64'h3C66663C66663C00;
      7'h39: r = 64'h3C66663E06663C00;
      default: r = '0;
    endcase
    return {32'h0, r, 32'h0};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizers, bit counter, idle timeout, parity.
// Emits one byte_valid_o pulse per well-formed 11-bit frame.
module ps2_frame_rx
  import ps2_char_glyph_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DFLT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    ck_q, dt_q;
  logic          ck_prev_q;
  logic [3:0]    bit_q;
  logic [9:0]    sh_q;
  logic [TW-1:0] to_q;
  logic [7:0]    byte_q;
  logic          vld_q;
  logic          fall, dat, frame_ok;

  assign dat  = dt_q[1];
  assign fall = ck_prev_q & ~ck_q[1];
  // sh_q[0]=start, sh_q[8:1]=data, sh_q[9]=parity; dat is the stop bit
  assign frame_ok = ~sh_q[0] & (^sh_q[9:1]) & dat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ck_q      <= 2'b11;
      dt_q      <= 2'b11;
      ck_prev_q <= 1'b1;
      bit_q     <= '0;
      sh_q      <= '0;
      to_q      <= '0;
      byte_q    <= '0;
      vld_q     <= 1'b0;
    end else begin
      ck_q      <= {ck_q[0], ps2_clk_i};
      dt_q      <= {dt_q[0], ps2_dat_i};
      ck_prev_q <= ck_q[1];
      vld_q     <= 1'b0;
      to_q      <= '0;
      if (fall) begin
        if (bit_q == 4'd10) begin
          bit_q <= '0;
          if (frame_ok) begin
            byte_q <= sh_q[8:1];
            vld_q  <= 1'b1;
          end
        end else begin
          bit_q <= bit_q + 4'd1;
          sh_q  <= {dat, sh_q[9:1]};
        end
      end else if (bit_q != 4'd0) begin
        if (to_q == TW'(TIMEOUT - 1)) begin
          bit_q <= '0;
        end else begin
          to_q <= to_q + TW'(1);
        end
      end
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = vld_q;

endmodule

// File: rtl/ps2_char_glyph_unit.sv
// PS/2 keyboard to uppercase ASCII with glyph lookup and a pixel counter.
// Break (F0) swallows the next code; extended prefix (E0) is dropped.
module ps2_char_glyph_unit
  import ps2_char_glyph_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DFLT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ps2_clk,
  input  logic         ps2_dat,
  input  logic         cnt_en,
  input  logic         cnt_clr,
  output logic [6:0]   ascii,
  output logic         ascii_valid,
  output logic [127:0] glyph,
  output logic [7:0]   count
);
  logic [7:0] rx_byte;
  logic       rx_vld;
  key_t       key;
  logic       brk_q;
  logic [6:0] ascii_q;
  logic       vld_q;
  logic [7:0] cnt_q;

  ps2_frame_rx #(
    .TIMEOUT(TIMEOUT)
  ) u_rx (
    .clk_i       (clk),
    .rst_i       (reset),
    .ps2_clk_i   (ps2_clk),
    .ps2_dat_i   (ps2_dat),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_vld)
  );

  assign key = scan_map(rx_byte);

  always_ff @(posedge clk) begin
    if (reset) begin
      brk_q   <= 1'b0;
      ascii_q <= ASCII_SPACE;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (rx_vld) begin
        if (rx_byte == SC_BREAK) begin
          brk_q <= 1'b1;
        end else if (rx_byte != SC_EXT) begin
          if (brk_q) begin
            brk_q <= 1'b0;
          end else if (key.hit) begin
            ascii_q <= key.code;
            vld_q   <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_en) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign ascii       = ascii_q;
  assign ascii_valid = vld_q;
  assign glyph       = glyph_rom(ascii_q);
  assign count       = cnt_q;

endmodule

// File: tb/tb_ps2_char_glyph_unit.sv
// Directed bench for ps2_char_glyph_unit with a frame-level key model.
// Per-cycle checks of count and of every ascii_valid pulse.
module tb_ps2_char_glyph_unit;
  import ps2_char_glyph_unit_pkg::*;

  localparam int TO = 200;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ps2_clk = 1'b1;
  logic         ps2_dat = 1'b1;
  logic         cnt_en = 1'b0;
  logic         cnt_clr = 1'b0;
  logic [6:0]   ascii;
  logic         ascii_valid;
  logic [127:0] glyph;
  logic [7:0]   count;

  int tests = 0;
  int fails = 0;

  logic [6:0] exp_q[$];
  logic [6:0] kmap[logic [7:0]];
  bit         brk = 0;
  logic [7:0] mcnt = 8'd0;
  bit         prev_v = 0;

  ps2_char_glyph_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .ascii      (ascii),
    .ascii_valid(ascii_valid),
    .glyph      (glyph),
    .count      (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset || cnt_clr) mcnt = 8'd0;
    else if (cnt_en) mcnt = mcnt + 8'd1;
  end

  always @(negedge clk) begin
    logic [6:0] e;
    if (reset) begin
      prev_v = 0;
    end else begin
      tests++;
      if (count !== mcnt) begin
        fails++;
        $display("FAIL count: got %0d expected %0d", count, mcnt);
      end
      if (ascii_valid) begin
        tests++;
        if (prev_v) begin
          fails++;
          $display("FAIL pulse_width: ascii_valid high two cycles");
        end else if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL spurious_valid: got ascii %h expected no pulse", ascii);
        end else begin
          e = exp_q.pop_front();
          if (ascii !== e || glyph !== glyph_rom(e)) begin
            fails++;
            $display("FAIL pulse_ascii: got %h glyph %h expected %h", ascii, glyph, e);
          end
        end
      end
      prev_v = ascii_valid;
    end
  end

  task automatic model_frame(input logic [7:0] b);
    if (b == 8'hF0) brk = 1;
    else if (b != 8'hE0) begin
      if (brk) brk = 0;
      else if (kmap.exists(b)) exp_q.push_back(kmap[b]);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input int n);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad, b, 1'b0};
    if (n == 11 && !bad) model_frame(b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ps2_dat = bits[i];
      repeat (4) @(negedge clk); ps2_clk = 1'b0;
      repeat (8) @(negedge clk); ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
    end
    @(negedge clk); ps2_dat = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic drained(input string nm);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d pending pulses expected 0", nm, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    brk = 0;
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] lc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15,
      8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
      8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 26; i++) kmap[lc[i]] = 7'(8'h41 + i);
    for (int i = 0; i < 10; i++) kmap[dc[i]] = 7'(8'h30 + i);
    kmap[8'h29] = 7'h20;

    do_reset();
    chk("rst_ascii", 128'(ascii), 128'h20);
    chk("rst_valid", 128'(ascii_valid), 128'h0);
    chk("rst_glyph", glyph, 128'h0);
    chk("rst_count", 128'(count), 128'h0);

    cnt_en = 1'b1;
    send_frame(8'h1C, 0, 11);
    cnt_en = 1'b0;
    drained("frame_A");
    chk("ascii_A", 128'(ascii), 128'h41);
    chk("glyph_A", glyph, {32'h0, 64'h183C66667E666600, 32'h0});

    send_frame(8'hF0, 0, 11);
    send_frame(8'h1C, 0, 11);
    drained("break_A");
    chk("break_hold", 128'(ascii), 128'h41);

    send_frame(8'h16, 1, 11);
    drained("bad_parity");
    chk("bad_par_hold", 128'(ascii), 128'h41);
    send_frame(8'h16, 0, 11);
    drained("frame_1");
    chk("ascii_1", 128'(ascii), 128'h31);
    chk("glyph_1", glyph, {32'h0, 64'h1818381818187E00, 32'h0});

    send_frame(8'h33, 0, 5);
    repeat (TO + 20) @(negedge clk);
    send_frame(8'h45, 0, 11);
    drained("timeout_0");
    chk("ascii_0", 128'(ascii), 128'h30);
    chk("glyph_0", glyph, {32'h0, 64'h3C666E7666663C00, 32'h0});

    send_frame(8'hE0, 0, 11);
    send_frame(8'h1D, 0, 11);
    drained("ext_W");
    chk("ascii_W", 128'(ascii), 128'h57);

    send_frame(8'h76, 0, 11);
    drained("unmapped");
    chk("unmapped_hold", 128'(ascii), 128'h57);

    send_frame(8'h29, 0, 11);
    drained("space");
    chk("ascii_sp", 128'(ascii), 128'h20);
    chk("glyph_sp", glyph, 128'h0);

    send_frame(8'hF0, 0, 11);
    send_frame(8'hE0, 0, 11);
    send_frame(8'h1C, 0, 11);
    send_frame(8'h1C, 0, 11);
    drained("brk_ext_A");
    chk("ascii_A2", 128'(ascii), 128'h41);

    send_frame(8'h24, 0, 6);
    do_reset();
    repeat (TO + 20) @(negedge clk);
    drained("mid_reset");
    chk("mid_rst_ascii", 128'(ascii), 128'h20);
    send_frame(8'h24, 0, 11);
    drained("frame_E");
    chk("ascii_E", 128'(ascii), 128'h45);

    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0; cnt_en = 1'b1;
    repeat (256) @(negedge clk);
    cnt_en = 1'b0;
    chk("cnt_wrap", 128'(count), 128'h0);
    cnt_en = 1'b1;
    repeat (127) @(negedge clk);
    chk("cnt_7f", 128'(count), 128'h7F);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_en = 1'b0; cnt_clr = 1'b0;
    chk("cnt_clr_pri", 128'(count), 128'h0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
